// File: rtl/alarm_zone_ctrl_if.sv
// Sensor/key inputs and indicator outputs of the zone alarm controller.
// The master side drives the pins; the slave side is the controller itself.
interface alarm_zone_ctrl_if #(
   parameter int ZONES = 4
);
   logic             arm;
   logic             disarm;
   logic [ZONES-1:0] door;
   logic [ZONES-1:0] zone_en;
   logic             alarm;
   logic             armed;
   logic             lamp;
   logic             arm_fault;
   logic [ZONES-1:0] zone_latch;
   logic [1:0]       state;

   modport master (
      output arm, disarm, door, zone_en,
      input  alarm, armed, lamp, arm_fault, zone_latch, state
   );

   modport slave (
      input  arm, disarm, door, zone_en,
      output alarm, armed, lamp, arm_fault, zone_latch, state
   );
endinterface

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm controller: per-zone door debounce feeding an
// arm / entry-delay / alarm state machine with tripped-zone latch and lamp.
module alarm_zone_ctrl #(
   parameter int ZONES       = 4,
   parameter int DEB_CYCLES  = 4,
   parameter int ENTRY_DELAY = 16,
   parameter int BLINK_DIV   = 8
) (
   input  logic              clk,
   input  logic              rst,
   alarm_zone_ctrl_if.slave  bus
);

   localparam int DCW = $clog2(DEB_CYCLES + 1);
   localparam int TW  = $clog2(ENTRY_DELAY + 1);
   localparam int BW  = $clog2(BLINK_DIV + 1);

   typedef enum logic [1:0] {
      S_DISARMED = 2'd0,
      S_ARMED    = 2'd1,
      S_ENTRY    = 2'd2,
      S_ALARM    = 2'd3
   } state_t;

   logic [ZONES-1:0] w_db;
   logic [ZONES-1:0] w_open_en;

   state_t           r_state;
   logic             r_alarm;
   logic             r_armed;
   logic             r_lamp;
   logic             r_arm_fault;
   logic [ZONES-1:0] r_zone_latch;
   logic [TW-1:0]    r_timer;
   logic [BW-1:0]    r_blink_cnt;

   // Each zone only adopts a new level after DEB_CYCLES consecutive disagreeing samples.
   genvar gi;
   generate
      for (gi = 0; gi < ZONES; gi++) begin : g_deb
         logic           r_bit;
         logic [DCW-1:0] r_cnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_bit <= 1'b0;
               r_cnt <= '0;
            end else if (bus.door[gi] == r_bit) begin
               r_cnt <= '0;
            end else if (r_cnt == DCW'(DEB_CYCLES - 1)) begin
               r_bit <= bus.door[gi];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_db[gi] = r_bit;
      end
   endgenerate

   assign w_open_en = w_db & bus.zone_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_DISARMED;
         r_alarm      <= 1'b0;
         r_armed      <= 1'b0;
         r_lamp       <= 1'b0;
         r_arm_fault  <= 1'b0;
         r_zone_latch <= '0;
         r_timer      <= '0;
         r_blink_cnt  <= '0;
      end else begin
         r_arm_fault <= 1'b0;
         if (bus.disarm) begin
            r_state      <= S_DISARMED;
            r_alarm      <= 1'b0;
            r_armed      <= 1'b0;
            r_lamp       <= 1'b0;
            r_zone_latch <= '0;
            r_timer      <= '0;
            r_blink_cnt  <= '0;
         end else begin
            case (r_state)
               S_DISARMED: begin
                  if (bus.arm) begin
                     if (w_open_en == '0) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                     end else begin
                        r_arm_fault <= 1'b1;
                     end
                  end
               end
               S_ARMED: begin
                  if (w_open_en != '0) begin
                     r_state      <= S_ENTRY;
                     r_timer      <= TW'(ENTRY_DELAY);
                     r_blink_cnt  <= '0;
                     r_lamp       <= 1'b1;
                     r_zone_latch <= r_zone_latch | w_open_en;
                  end
               end
               S_ENTRY: begin
                  r_zone_latch <= r_zone_latch | w_open_en;
                  if (r_timer == TW'(1)) begin
                     r_state     <= S_ALARM;
                     r_alarm     <= 1'b1;
                     r_lamp      <= 1'b1;
                     r_timer     <= '0;
                     r_blink_cnt <= '0;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                     // Blink phase restarts on every ENTRY, so the lamp always begins lit.
                     if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                        r_lamp      <= ~r_lamp;
                        r_blink_cnt <= '0;
                     end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                     end
                  end
               end
               S_ALARM: begin
                  r_zone_latch <= r_zone_latch | w_open_en;
               end
               default: begin
                  r_state <= S_DISARMED;
               end
            endcase
         end
      end
   end

   assign bus.state      = r_state;
   assign bus.alarm      = r_alarm;
   assign bus.armed      = r_armed;
   assign bus.lamp       = r_lamp;
   assign bus.arm_fault  = r_arm_fault;
   assign bus.zone_latch = r_zone_latch;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Self-checking bench for alarm_zone_ctrl: directed scenarios then random
// stimulus, every cycle compared against a behavioural model.
module tb_alarm_zone_ctrl;

   localparam int Z     = 4;
   localparam int DEB   = 4;
   localparam int DELAY = 16;
   localparam int BLINK = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   alarm_zone_ctrl_if #(.ZONES(Z)) bus ();

   alarm_zone_ctrl #(
      .ZONES      (Z),
      .DEB_CYCLES (DEB),
      .ENTRY_DELAY(DELAY),
      .BLINK_DIV  (BLINK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: debounce as "last DEB samples all disagree", entry as elapsed age.
   logic [Z-1:0] m_db;
   logic [Z-1:0] m_latch;
   logic [Z-1:0] m_hist[$];
   int           m_st;
   int           m_age;
   bit           m_fault;

   function automatic void model_reset();
      m_db    = '0;
      m_latch = '0;
      m_st    = 0;
      m_age   = 0;
      m_fault = 1'b0;
      m_hist.delete();
   endfunction

   function automatic bit m_lamp();
      if (m_st == 3) return 1'b1;
      if (m_st == 2) return ((m_age / BLINK) % 2) == 0;
      return 1'b0;
   endfunction

   function automatic void model_edge();
      logic [Z-1:0] open;
      bit           all_diff;
      open    = m_db & bus.zone_en;
      m_fault = 1'b0;
      if (bus.disarm) begin
         m_st    = 0;
         m_latch = '0;
         m_age   = 0;
      end else begin
         case (m_st)
            0: if (bus.arm) begin
                  if (open == '0) m_st = 1;
                  else            m_fault = 1'b1;
               end
            1: if (open != '0) begin
                  m_st    = 2;
                  m_age   = 0;
                  m_latch = m_latch | open;
               end
            2: begin
                  m_latch = m_latch | open;
                  m_age++;
                  if (m_age == DELAY) m_st = 3;
               end
            default: m_latch = m_latch | open;
         endcase
      end
      m_hist.push_back(bus.door);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      if (m_hist.size() == DEB) begin
         for (int i = 0; i < Z; i++) begin
            all_diff = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) m_db[i] = bus.door[i];
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".state"},  32'(bus.state),      32'(m_st));
      check({tag, ".alarm"},  32'(bus.alarm),      32'(m_st == 3));
      check({tag, ".armed"},  32'(bus.armed),      32'(m_st != 0));
      check({tag, ".lamp"},   32'(bus.lamp),       32'(m_lamp()));
      check({tag, ".fault"},  32'(bus.arm_fault),  32'(m_fault));
      check({tag, ".latch"},  32'(bus.zone_latch), 32'(m_latch));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      compare_all(tag);
      $display("cyc=%0d %s arm=%0b dis=%0b door=%b en=%b st=%0d lamp=%0b flt=%0b latch=%b",
               cyc, tag, bus.arm, bus.disarm, bus.door, bus.zone_en,
               bus.state, bus.lamp, bus.arm_fault, bus.zone_latch);
   endtask

   task automatic drive(input logic a, input logic d, input logic [Z-1:0] dr,
                        input logic [Z-1:0] en, input int n, input string tag);
      bus.arm     = a;
      bus.disarm  = d;
      bus.door    = dr;
      bus.zone_en = en;
      repeat (n) step(tag);
   endtask

   initial begin
      bus.arm     = 1'b0;
      bus.disarm  = 1'b0;
      bus.door    = '0;
      bus.zone_en = 4'b1111;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      #3 rst = 1'b0;

      // Debounce glitch rejection while armed
      drive(1, 0, 4'b0000, 4'b1111, 1, "arm");
      drive(0, 0, 4'b0001, 4'b1111, 3, "glitch");
      drive(0, 0, 4'b0000, 4'b1111, 2, "glitch_lo");
      check("glitch_state", 32'(bus.state), 32'd1);
      drive(0, 0, 4'b0001, 4'b1111, 5, "deb_hold");
      check("deb_entry", 32'(bus.state), 32'd2);
      drive(0, 0, 4'b0000, 4'b1111, 20, "to_alarm");
      check("alarm_hold", 32'(bus.alarm), 32'd1);
      check("latch_z0", 32'(bus.zone_latch), 32'h1);
      drive(0, 1, 4'b0000, 4'b1111, 1, "disarm");

      // Entry timeout and lamp blink
      drive(1, 0, 4'b0000, 4'b1111, 1, "arm2");
      drive(0, 0, 4'b0010, 4'b1111, 5, "z1_open");
      drive(0, 0, 4'b0010, 4'b1111, 15, "entry");
      check("entry_last", 32'(bus.state), 32'd2);
      check("lamp_off", 32'(bus.lamp), 32'd0);
      drive(0, 0, 4'b0010, 4'b1111, 1, "timeout");
      check("alarm_on", 32'(bus.alarm), 32'd1);
      check("latch_z1", 32'(bus.zone_latch), 32'h2);
      drive(0, 0, 4'b0000, 4'b1111, 6, "door_closed");
      check("alarm_sticky", 32'(bus.alarm), 32'd1);
      drive(0, 1, 4'b0000, 4'b1111, 1, "disarm2");
      check("latch_clr", 32'(bus.zone_latch), 32'h0);

      // Disarm with arm during ENTRY
      drive(1, 0, 4'b0000, 4'b1111, 1, "arm3");
      drive(0, 0, 4'b0100, 4'b1111, 14, "entry3");
      drive(1, 1, 4'b0100, 4'b1111, 1, "both");
      check("both_state", 32'(bus.state), 32'd0);
      drive(0, 0, 4'b0000, 4'b1111, 5, "settle");

      // Arm refusal, then mask the open zone
      drive(0, 0, 4'b1000, 4'b1111, 5, "z3_open");
      drive(1, 0, 4'b1000, 4'b1111, 2, "refuse");
      check("fault_pulse", 32'(bus.arm_fault), 32'd1);
      check("refuse_state", 32'(bus.state), 32'd0);
      drive(1, 0, 4'b1000, 4'b0111, 1, "masked_arm");
      check("masked_state", 32'(bus.state), 32'd1);
      drive(0, 1, 4'b0000, 4'b1111, 5, "disarm4");

      // Multi-zone trip
      drive(1, 0, 4'b0000, 4'b1111, 1, "arm5");
      drive(0, 0, 4'b0001, 4'b1111, 5, "z0");
      drive(0, 0, 4'b0101, 4'b1111, 20, "z0z2");
      check("multi_latch", 32'(bus.zone_latch), 32'h5);
      check("multi_state", 32'(bus.state), 32'd3);

      // Asynchronous reset mid-ALARM, released between edges
      rst = 1'b1;
      model_reset();
      #1;
      compare_all("async_rst");
      #2 rst = 1'b0;
      drive(0, 0, 4'b0000, 4'b1111, 1, "post_rst");

      // Random traffic
      bus.zone_en = 4'b1111;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < Z; i++)
            if ($urandom_range(11) == 0) bus.door[i] = ~bus.door[i];
         bus.arm    = ($urandom_range(7) == 0);
         bus.disarm = ($urandom_range(39) == 0);
         if ($urandom_range(49) == 0) bus.zone_en = 4'($urandom);
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
